// File: rtl/delay_monitor_if.sv
// Observation bus between a gate-level stimulus/response pair and the delay monitor.
// The master side drives stimulus and DUT output; the slave side (the monitor) reports results.
interface delay_monitor_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] stim;
  logic             y;
  logic             busy;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_delay;
  logic [CNT_W-1:0] min_delay;
  logic [CNT_W-1:0] max_delay;
  logic [CNT_W-1:0] meas_count;
  logic             timeout;
  logic             retrig;

  modport master (
    output en, stim, y,
    input  busy, meas_valid, meas_delay, min_delay, max_delay, meas_count, timeout, retrig
  );

  modport slave (
    input  en, stim, y,
    output busy, meas_valid, meas_delay, min_delay, max_delay, meas_count, timeout, retrig
  );
endinterface

// File: rtl/delay_monitor.sv
// Measures stimulus-to-output delay of a gate-level DUT in clock cycles, keeping running
// min/max statistics, a saturating sample count and timeout/retrigger event pulses.
module delay_monitor #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input logic             clk,
  input logic             rst,
  delay_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StMeasure
  } state_e;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] stim_q;
  logic             y_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] meas_delay_q, meas_delay_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, timeout_q, timeout_d, retrig_q, retrig_d;

  logic             stim_chg;
  logic             y_chg;
  logic             rec;
  logic [CNT_W-1:0] rec_val;

  assign stim_chg = (mon.stim != stim_q);
  assign y_chg    = (mon.y != y_q);

  // Next-state and event decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rec       = 1'b0;
    rec_val   = '0;
    timeout_d = 1'b0;
    retrig_d  = 1'b0;

    if (!mon.en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArmed;
        end

        StArmed: begin
          if (stim_chg && y_chg) begin
            rec     = 1'b1;
            rec_val = '0;
          end else if (stim_chg) begin
            state_d = StMeasure;
            cnt_d   = CntOne;
          end
        end

        StMeasure: begin
          if (y_chg) begin
            rec     = 1'b1;
            rec_val = cnt_q;
            if (stim_chg) begin
              // A fresh stimulus edge in the same cycle starts the next measurement.
              cnt_d = CntOne;
            end else begin
              state_d = StArmed;
              cnt_d   = '0;
            end
          end else if (stim_chg) begin
            retrig_d = 1'b1;
            cnt_d    = CntOne;
          end else if (cnt_q == TimeoutCnt) begin
            timeout_d = 1'b1;
            state_d   = StArmed;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end

        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Statistics update on a recorded measurement.
  always_comb begin
    meas_delay_d = meas_delay_q;
    min_d        = min_q;
    max_d        = max_q;
    count_d      = count_q;
    if (rec) begin
      meas_delay_d = rec_val;
      if (rec_val < min_q) begin
        min_d = rec_val;
      end
      if (rec_val > max_q) begin
        max_d = rec_val;
      end
      if (count_q != CntMax) begin
        count_d = count_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      stim_q       <= '0;
      y_q          <= 1'b0;
      cnt_q        <= '0;
      meas_delay_q <= '0;
      min_q        <= CntMax;
      max_q        <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      retrig_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      stim_q       <= mon.stim;
      y_q          <= mon.y;
      cnt_q        <= cnt_d;
      meas_delay_q <= meas_delay_d;
      min_q        <= min_d;
      max_q        <= max_d;
      count_q      <= count_d;
      valid_q      <= rec;
      timeout_q    <= timeout_d;
      retrig_q     <= retrig_d;
    end
  end

  assign mon.busy       = (state_q == StMeasure);
  assign mon.meas_valid = valid_q;
  assign mon.meas_delay = meas_delay_q;
  assign mon.min_delay  = min_q;
  assign mon.max_delay  = max_q;
  assign mon.meas_count = count_q;
  assign mon.timeout    = timeout_q;
  assign mon.retrig     = retrig_q;

endmodule

// File: tb/tb_delay_monitor.sv
// Directed, table-driven bench for delay_monitor plus hand-written timeout, saturation and
// mid-measurement reset sequences.
module tb_delay_monitor;

  logic clk;
  logic rst;

  delay_monitor_if #(.WIDTH(3), .CNT_W(8)) bus ();

  delay_monitor #(
    .WIDTH  (3),
    .CNT_W  (8),
    .TIMEOUT(200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] stim;
    logic       y;
    logic       busy;
    logic       valid;
    logic [7:0] dly;
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] cnt;
    logic       to;
    logic       rt;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input logic r, input logic e, input logic [2:0] s, input logic yy,
                              input logic b, input logic v, input logic [7:0] d,
                              input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] c,
                              input logic t, input logic rt);
    vec_t x;
    x.rst = r;  x.en = e;   x.stim = s; x.y = yy;
    x.busy = b; x.valid = v; x.dly = d; x.mn = mn;
    x.mx = mx;  x.cnt = c;  x.to = t;   x.rt = rt;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic b, input logic v,
                               input logic [7:0] d, input logic [7:0] mn, input logic [7:0] mx,
                               input logic [7:0] c, input logic t, input logic rt);
    check({tag, " busy"},       32'(bus.busy),       32'(b));
    check({tag, " meas_valid"}, 32'(bus.meas_valid), 32'(v));
    check({tag, " meas_delay"}, 32'(bus.meas_delay), 32'(d));
    check({tag, " min_delay"},  32'(bus.min_delay),  32'(mn));
    check({tag, " max_delay"},  32'(bus.max_delay),  32'(mx));
    check({tag, " meas_count"}, 32'(bus.meas_count), 32'(c));
    check({tag, " timeout"},    32'(bus.timeout),    32'(t));
    check({tag, " retrig"},     32'(bus.retrig),     32'(rt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_to;
    int bad_busy;
    int bad_meas;
    logic [7:0] exp_cnt;

    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.stim = 3'b000;
    bus.y    = 1'b0;

    // Reset, then 3-cycle delay, same-cycle change, retrigger.
    add(1, 0, 3'b000, 0,  0, 0, 0, 255, 0, 0, 0, 0);
    add(0, 1, 3'b001, 0,  0, 0, 0, 255, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 3'b011, 0,  1, 0, 0, 255, 0, 0, 0, 0);
    add(0, 1, 3'b011, 1,  0, 1, 3, 3, 3, 1, 0, 0);
    add(0, 1, 3'b011, 1,  0, 0, 3, 3, 3, 1, 0, 0);
    add(0, 1, 3'b010, 0,  0, 1, 0, 0, 3, 2, 0, 0);
    add(0, 1, 3'b010, 0,  0, 0, 0, 0, 3, 2, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 1, 3'b110, 0,  1, 0, 0, 0, 3, 2, 0, 0);
    add(0, 1, 3'b111, 0,  1, 0, 0, 0, 3, 2, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 3'b111, 0,  1, 0, 0, 0, 3, 2, 0, 0);
    add(0, 1, 3'b111, 1,  0, 1, 4, 0, 4, 3, 0, 0);
    // Reset again, delays 5, 2, 9, then en drop mid-measurement.
    add(1, 1, 3'b000, 0,  0, 0, 0, 255, 0, 0, 0, 0);
    add(0, 1, 3'b000, 0,  0, 0, 0, 255, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 3'b001, 0,  1, 0, 0, 255, 0, 0, 0, 0);
    add(0, 1, 3'b001, 1,  0, 1, 5, 5, 5, 1, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 1, 3'b000, 1,  1, 0, 5, 5, 5, 1, 0, 0);
    add(0, 1, 3'b000, 0,  0, 1, 2, 2, 5, 2, 0, 0);
    for (int i = 0; i < 9; i++) add(0, 1, 3'b001, 0,  1, 0, 2, 2, 5, 2, 0, 0);
    add(0, 1, 3'b001, 1,  0, 1, 9, 2, 9, 3, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 1, 3'b010, 1,  1, 0, 9, 2, 9, 3, 0, 0);
    add(0, 0, 3'b010, 1,  0, 0, 9, 2, 9, 3, 0, 0);
    add(0, 0, 3'b010, 0,  0, 0, 9, 2, 9, 3, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 1, 3'b010, 0,  0, 0, 9, 2, 9, 3, 0, 0);

    foreach (vecs[i]) begin
      rst      = vecs[i].rst;
      bus.en   = vecs[i].en;
      bus.stim = vecs[i].stim;
      bus.y    = vecs[i].y;
      step();
      check_outputs($sformatf("row%0d", i), vecs[i].busy, vecs[i].valid, vecs[i].dly,
                    vecs[i].mn, vecs[i].mx, vecs[i].cnt, vecs[i].to, vecs[i].rt);
    end

    // Timeout: pulse lands on the TIMEOUT-th edge after entering MEASURE.
    bus.stim = 3'b011;
    step();
    check("to_entry busy", 32'(bus.busy), 32'd1);
    bad_to   = 0;
    bad_busy = 0;
    for (int i = 0; i < 199; i++) begin
      step();
      if (bus.timeout !== 1'b0) bad_to++;
      if (bus.busy !== 1'b1) bad_busy++;
    end
    check("to_early_pulses", 32'(bad_to), 32'd0);
    check("to_busy_held", 32'(bad_busy), 32'd0);
    step();
    check_outputs("to_edge", 0, 0, 9, 2, 9, 3, 1, 0);
    step();
    check("to_pulse_width", 32'(bus.timeout), 32'd0);

    // 260 delay-1 measurements: count saturates at 255.
    bad_meas = 0;
    for (int i = 0; i < 260; i++) begin
      bus.stim = bus.stim ^ 3'b001;
      step();
      bus.y = ~bus.y;
      step();
      exp_cnt = (4 + i > 255) ? 8'd255 : 8'(4 + i);
      if (bus.meas_valid !== 1'b1 || bus.meas_delay !== 8'd1 || bus.meas_count !== exp_cnt)
        bad_meas++;
    end
    check("sat_loop_errors", 32'(bad_meas), 32'd0);
    check("sat_count", 32'(bus.meas_count), 32'd255);
    check("sat_min", 32'(bus.min_delay), 32'd1);
    check("sat_max", 32'(bus.max_delay), 32'd9);

    // Reset in the middle of a measurement.
    bus.stim = bus.stim ^ 3'b100;
    step();
    check("pre_rst busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    check_outputs("mid_rst", 0, 0, 0, 255, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    check("post_rst busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
